// File: rtl/conv_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : conv_pkg                                                          |
// | Brief  : Shared types and helpers for the 2-D convolution engine:          |
// |          FSM state enum and the output-dimension helper.                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package conv_pkg;

  // Job sequencing: IDLE waits for start, COMPUTE runs one MAC per cycle,
  // DONE is the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  // Side length of a "valid" convolution result.
  function automatic int out_dim(input int n, input int k);
    return n - k + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_engine_if.sv
// +----------------------------------------------------------------------------+
// | Module : conv2d_engine_if                                                  |
// | Brief  : Job/bus interface of conv2d_engine.                               |
// |   start     request (sampled by the engine only when idle)                |
// |   in_flat   N*N*DW  row-major signed input matrix                          |
// |   kern_flat K*K*DW  row-major signed kernel                                |
// |   busy      engine is computing                                            |
// |   done      one-cycle completion pulse                                     |
// |   out_flat  M*M*AW  row-major signed results, M = N-K+1                    |
// |   Modports: master (job issuer), slave (engine).                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface conv2d_engine_if
  import conv_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 2,
  parameter int DW = 16,
  parameter int AW = 2*DW + $clog2(K*K)
);
  localparam int M = out_dim(N, K);

  logic                start;
  logic [N*N*DW-1:0]   in_flat;
  logic [K*K*DW-1:0]   kern_flat;
  logic                busy;
  logic                done;
  logic [M*M*AW-1:0]   out_flat;

  modport master (
    output start, in_flat, kern_flat,
    input  busy, done, out_flat
  );

  modport slave (
    input  start, in_flat, kern_flat,
    output busy, done, out_flat
  );

endinterface

`default_nettype wire

// File: rtl/conv_mac.sv
// +----------------------------------------------------------------------------+
// | Module : conv_mac                                                          |
// | Brief  : Signed multiply-accumulate slice. Full-precision DW x DW product  |
// |          sign-extended to AW and added to a wrapping AW-bit accumulator.   |
// |   clk, reset  clock / synchronous active-high reset                        |
// |   clr         load accumulator with 0 (priority over en)                   |
// |   en          accumulate a*b                                               |
// |   a, b        signed DW operands                                           |
// |   sum_next    acc + sext(a*b), combinational (used for final-tap store)    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_mac #(
  parameter int DW = 16,
  parameter int AW = 34
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] sum_next
);

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc;

  // Widen before multiplying so the product is computed at full 2*DW width.
  assign a_ext    = (2*DW)'(a);
  assign b_ext    = (2*DW)'(b);
  assign prod     = a_ext * b_ext;
  assign prod_ext = AW'(prod);
  assign sum_next = acc + prod_ext;   // wraps modulo 2^AW

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv2d_engine.sv
// +----------------------------------------------------------------------------+
// | Module : conv2d_engine                                                     |
// | Brief  : Sequential 2-D valid convolution, one MAC per clock.              |
// |          N x N signed input, K x K runtime kernel, M x M results.          |
// |   clk    clock, rising edge                                                |
// |   reset  synchronous active-high reset                                     |
// |   bus    conv2d_engine_if.slave (start/in_flat/kern_flat/busy/done/       |
// |          out_flat)                                                         |
// |   Config macro CONV_RELU_EN: negative sums are stored as 0 (the           |
// |          accumulator itself is never clamped).                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv2d_engine
  import conv_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 2,
  parameter int DW = 16,
  parameter int AW = 2*DW + $clog2(K*K)
) (
  input  logic           clk,
  input  logic           reset,
  conv2d_engine_if.slave bus
);

  localparam int M   = out_dim(N, K);
  localparam int MW  = (M > 1) ? $clog2(M) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int XIW = $clog2(N*N);
  localparam int WIW = (K*K > 1) ? $clog2(K*K) : 1;
  localparam int OIW = (M*M > 1) ? $clog2(M*M) : 1;

  conv_state_t state, state_next;

  logic signed [DW-1:0] x_mem   [N*N];
  logic signed [DW-1:0] w_mem   [K*K];
  logic signed [AW-1:0] out_mem [M*M];

  logic [MW-1:0] i, j;
  logic [KW-1:0] p, q;

  logic last_q, last_p, last_j, last_i, last_tap, job_end;
  logic capture, mac_clr, mac_en;

  logic [XIW-1:0]       x_idx;
  logic [WIW-1:0]       w_idx;
  logic [OIW-1:0]       o_idx;
  logic signed [DW-1:0] tap_x, tap_w;
  logic signed [AW-1:0] sum_next, store_val;

  assign last_q   = (q == KW'(K - 1));
  assign last_p   = (p == KW'(K - 1));
  assign last_j   = (j == MW'(M - 1));
  assign last_i   = (i == MW'(M - 1));
  assign last_tap = last_p && last_q;
  assign job_end  = last_tap && last_j && last_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          mac_clr    = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        // Clear wins over accumulate: the finished sum leaves through
        // sum_next and the next output window starts from zero.
        mac_clr = last_tap;
        if (job_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == COMPUTE);
  assign bus.done = (state == DONE);

  // ------------------------------------------------------ operand capture
  // Operands are latched at start so the caller may change the bus freely
  // while a job is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < N*N; e++) x_mem[e] <= '0;
      for (int e = 0; e < K*K; e++) w_mem[e] <= '0;
    end else if (capture) begin
      for (int e = 0; e < N*N; e++) x_mem[e] <= bus.in_flat[e*DW +: DW];
      for (int e = 0; e < K*K; e++) w_mem[e] <= bus.kern_flat[e*DW +: DW];
    end
  end

  // ------------------------------------------------------------ counters
  // Loop nest i (outer) > j > p > q (inner).
  always_ff @(posedge clk) begin
    if (reset || capture) begin
      i <= '0;
      j <= '0;
      p <= '0;
      q <= '0;
    end else if (state == COMPUTE) begin
      if (!last_q) begin
        q <= q + KW'(1);
      end else begin
        q <= '0;
        if (!last_p) begin
          p <= p + KW'(1);
        end else begin
          p <= '0;
          if (!last_j) begin
            j <= j + MW'(1);
          end else begin
            j <= '0;
            i <= last_i ? '0 : i + MW'(1);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ tap mux
  always_comb begin
    x_idx = XIW'((int'(i) + int'(p)) * N + int'(j) + int'(q));
    w_idx = WIW'(int'(p) * K + int'(q));
    o_idx = OIW'(int'(i) * M + int'(j));
    tap_x = x_mem[x_idx];
    tap_w = w_mem[w_idx];
  end

  conv_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (tap_x),
    .b        (tap_w),
    .sum_next (sum_next)
  );

  // ------------------------------------------------------- result store
`ifdef CONV_RELU_EN
  assign store_val = sum_next[AW-1] ? '0 : sum_next;
`else
  assign store_val = sum_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < M*M; e++) out_mem[e] <= '0;
    end else if (state == COMPUTE && last_tap) begin
      out_mem[o_idx] <= store_val;
    end
  end

  for (genvar e = 0; e < M*M; e++) begin : g_out
    assign bus.out_flat[e*AW +: AW] = out_mem[e];
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_engine.sv
// +----------------------------------------------------------------------------+
// | Module : tb_conv2d_engine                                                  |
// | Brief  : Self-checking bench for conv2d_engine. Three instances:           |
// |          u0 N=3,K=2,DW=16 (scoreboarded every cycle, random jobs),        |
// |          u1 N=3,K=2,DW=8 (extreme operands), u2 N=4,K=4 (M=1).            |
// |          Honours CONV_RELU_EN in its expectations.                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_conv2d_engine;
  import conv_pkg::*;

  localparam int AW0 = 34;
  localparam int AW1 = 18;
  localparam int AW2 = 36;
  localparam int KK0 = 4;
  localparam int MM0 = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv2d_engine_if #(.N(3), .K(2), .DW(16), .AW(AW0)) b0 ();
  conv2d_engine_if #(.N(3), .K(2), .DW(8),  .AW(AW1)) b1 ();
  conv2d_engine_if #(.N(4), .K(4), .DW(16), .AW(AW2)) b2 ();

  conv2d_engine #(.N(3), .K(2), .DW(16), .AW(AW0)) u0 (.clk(clk), .reset(rst), .bus(b0));
  conv2d_engine #(.N(3), .K(2), .DW(8),  .AW(AW1)) u1 (.clk(clk), .reset(rst), .bus(b1));
  conv2d_engine #(.N(4), .K(4), .DW(16), .AW(AW2)) u2 (.clk(clk), .reset(rst), .bus(b2));

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------- reference model
  function automatic longint elem(input logic [255:0] f, input int e, input int dw);
    logic [255:0] s;
    longint v;
    s = f >> (e * dw);
    v = longint'(s[63:0]) & ((longint'(1) << dw) - 1);
    if (v >= (longint'(1) << (dw - 1))) v -= (longint'(1) << dw);
    return v;
  endfunction

  function automatic longint relu(input longint v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint conv_ref(input logic [255:0] x, input logic [255:0] w,
                                      input int n, input int k, input int dw,
                                      input int i, input int j);
    longint s = 0;
    for (int p = 0; p < k; p++)
      for (int q = 0; q < k; q++)
        s += elem(x, (i + p) * n + j + q, dw) * elem(w, p * k + q, dw);
    return relu(s);
  endfunction

  // Job-level timing model of u0: results are known at capture, element e
  // appears after (e+1)*K*K compute cycles, done follows the last one.
  int     m_phase = 0;   // 0 idle, 1 computing, 2 done pulse
  int     m_cnt   = 0;
  longint m_res [MM0];
  longint m_out [MM0] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      for (int e = 0; e < MM0; e++) m_out[e] = 0;
    end else if (m_phase == 0) begin
      if (b0.start) begin
        for (int e = 0; e < MM0; e++)
          m_res[e] = conv_ref(256'(b0.in_flat), 256'(b0.kern_flat), 3, 2, 16, e / 2, e % 2);
        m_cnt   = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_cnt++;
      if (m_cnt % KK0 == 0) m_out[m_cnt / KK0 - 1] = m_res[m_cnt / KK0 - 1];
      if (m_cnt == MM0 * KK0) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  function automatic longint out0(input int e);
    logic signed [AW0-1:0] t;
    t = b0.out_flat[e*AW0 +: AW0];
    return t;
  endfunction

  // Per-cycle scoreboard on u0.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_busy", longint'(b0.busy), longint'(m_phase == 1));
      chk("sb_done", longint'(b0.done), longint'(m_phase == 2));
      for (int e = 0; e < MM0; e++)
        chk($sformatf("sb_out%0d", e), out0(e), m_out[e]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  task automatic chk_out0(input string tag, input longint e0, input longint e1,
                          input longint e2, input longint e3);
    chk({tag, "_o0"}, out0(0), e0);
    chk({tag, "_o1"}, out0(1), e1);
    chk({tag, "_o2"}, out0(2), e2);
    chk({tag, "_o3"}, out0(3), e3);
  endtask

  // Issue one job on u0 and return the cycle (after the capture edge) in
  // which done was seen, or -1 if the budget ran out.
  task automatic job0(input logic [143:0] x, input logic [63:0] w, input int zero_at,
                      input bit noise, output int done_cyc);
    @(negedge clk);
    b0.in_flat   = x;
    b0.kern_flat = w;
    b0.start     = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) b0.start = 1'b0;
      if (noise && c >= 2 && c <= 14) b0.start = 1'($urandom_range(0, 1));
      if (noise && c == 5) b0.in_flat = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
      if (noise && c == 6) b0.kern_flat = {$urandom, $urandom};
      if (c == 15) b0.start = 1'b0;
      if (c == zero_at) b0.in_flat = '0;
      if (b0.done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [143:0] x1;
  logic [63:0]  w1, w3, wr;
  logic [143:0] xr;
  int           dc, ndone, first, second, extra;
  logic signed [AW1-1:0] t1;
  logic signed [AW2-1:0] t2;

  initial begin
    for (int e = 0; e < 9; e++) x1[e*16 +: 16] = 16'(e + 1);
    w1 = {16'd0, 16'd1, 16'd0, 16'd1};          // [1,0;1,0]
    w3 = {16'hffff, 16'd0, 16'd0, 16'hffff};    // [-1,0;0,-1]

    rst = 1'b1;
    b0.start = 0; b0.in_flat = '0; b0.kern_flat = '0;
    b1.start = 0; b1.in_flat = '0; b1.kern_flat = '0;
    b2.start = 0; b2.in_flat = '0; b2.kern_flat = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(b0.busy), 0);
    chk("rst_done", longint'(b0.done), 0);
    chk("rst_out_zero", longint'(b0.out_flat != '0), 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Model anchor: hand-computed windows.
    chk("model_anchor0", conv_ref(256'(x1), 256'(w1), 3, 2, 16, 1, 1), 13);
    chk("model_anchor1", conv_ref(256'(x1), 256'(w3), 3, 2, 16, 0, 1), relu(-8));

    // Basic job.
    job0(x1, w1, 0, 0, dc);
    chk("t1_done_cycle", dc, 17);
    chk_out0("t1", 5, 7, 11, 13);

    // Input changed mid-job must not matter.
    job0(x1, w1, 5, 0, dc);
    chk("t2_done_cycle", dc, 17);
    chk_out0("t2", 5, 7, 11, 13);

    // Negative kernel.
    job0(x1, w3, 0, 0, dc);
    chk("t3_done_cycle", dc, 17);
`ifdef CONV_RELU_EN
    chk_out0("t3", 0, 0, 0, 0);
`else
    chk_out0("t3", -6, -8, -12, -14);
`endif

    // Reset in COMPUTE cycle 7 aborts the job.
    @(negedge clk);
    b0.in_flat = x1; b0.kern_flat = w1; b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_pre_busy", longint'(b0.busy), 1);
    chk("t5_pre_out0", out0(0), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", longint'(b0.busy), 0);
    chk("t5_done", longint'(b0.done), 0);
    chk("t5_out_zero", longint'(b0.out_flat != '0), 0);
    job0(x1, w1, 0, 0, dc);
    chk("t5_done_cycle", dc, 17);
    chk_out0("t5", 5, 7, 11, 13);

    // start pulses while busy are ignored and not queued.
    job0(x1, w3, 0, 1, dc);
    chk("t6a_done_cycle", dc, 17);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b0.done || b0.busy) extra++;
    end
    chk("t6a_no_queued_job", extra, 0);

    // start held high: back-to-back jobs.
    @(negedge clk);
    b0.in_flat = x1; b0.kern_flat = w1; b0.start = 1'b1;
    @(posedge clk);
    ndone = 0; first = -1; second = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 40) b0.start = 1'b0;
      if (b0.done) begin
        ndone++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    chk("t6b_pulses", ndone, 2);
    chk("t6b_first", first, 17);
    chk("t6b_second", second, 35);
    extra = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!b0.busy && !b0.done) begin
        extra = c;
        break;
      end
    end
    chk("t6b_drain_timeout", longint'(extra < 0), 0);

    // DW=8 extremes.
    @(negedge clk);
    b1.in_flat = {9{8'h80}}; b1.kern_flat = {4{8'h80}}; b1.start = 1'b1;
    @(posedge clk);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) b1.start = 1'b0;
      if (b1.done) begin dc = c; break; end
    end
    chk("t4_done_cycle", dc, 17);
    for (int e = 0; e < 4; e++) begin
      t1 = b1.out_flat[e*AW1 +: AW1];
      chk($sformatf("t4_out%0d", e), t1, 65536);
    end

    // K=N, single output.
    @(negedge clk);
    b2.in_flat = {16{16'd1}}; b2.kern_flat = {16{16'd1}}; b2.start = 1'b1;
    @(posedge clk);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) b2.start = 1'b0;
      if (b2.done) begin dc = c; break; end
    end
    chk("t7_done_cycle", dc, 17);
    t2 = b2.out_flat;
    chk("t7_out", t2, 16);

    // Random jobs on u0; the scoreboard checks every cycle.
    for (int n = 0; n < 25; n++) begin
      for (int e = 0; e < 9; e++) xr[e*16 +: 16] = pick16();
      for (int e = 0; e < 4; e++) wr[e*16 +: 16] = pick16();
      job0(xr, wr, 0, 1'($urandom_range(0, 1)), dc);
      chk("rnd_done_cycle", dc, 17);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
